vga_fetch: RTL and testbench

//  Scan-out engine for the shared CPU/VGA memory. Generates 640x480@60 VGA timing
//  and drives the read-only video port of the memory (va -> vd, one-clock registered read).

---
 rtl/vga_pkg.sv | 40 ++++
 rtl/vga_timing.sv | 60 ++++++
 rtl/vga_fetch.sv | 236 +++++++++++++++++++++++
 tb/tb_vga_fetch.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA scan-out engine.
//  - 640x480@60 horizontal/vertical timing constants (10-bit, pixel/line units)
//  - fetch_state_t: states of the video-port fetch FSM
//  - rgb_t: one 24-bit colour as three 8-bit channels
//  - clog2_min1: counter-width helper that never returns 0
package vga_pkg;

  // Horizontal timing in pixels
  localparam logic [9:0] H_VIS    = 10'd640;
  localparam logic [9:0] H_FP     = 10'd16;
  localparam logic [9:0] H_SYNC   = 10'd96;
  localparam logic [9:0] H_BP     = 10'd48;
  localparam logic [9:0] H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam logic [9:0] H_SYNC_S = H_VIS + H_FP;
  localparam logic [9:0] H_SYNC_E = H_SYNC_S + H_SYNC;
  localparam logic [9:0] H_LAST   = H_TOTAL - 10'd1;

  // Vertical timing in lines
  localparam logic [9:0] V_VIS    = 10'd480;
  localparam logic [9:0] V_FP     = 10'd10;
  localparam logic [9:0] V_SYNC   = 10'd2;
  localparam logic [9:0] V_BP     = 10'd33;
  localparam logic [9:0] V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] V_SYNC_S = V_VIS + V_FP;
  localparam logic [9:0] V_SYNC_E = V_SYNC_S + V_SYNC;
  localparam logic [9:0] V_LAST   = V_TOTAL - 10'd1;

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, CAPT} fetch_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel-tick divider and 800x525 raster counters.
// Ports:
//  clk, reset       system clock, synchronous active-high reset
//  o_tick           one-clk pulse when the divider wraps (one per pixel)
//  o_hc, o_vc       current pixel column / line
//  o_hs_raw         unregistered hsync (active low) for o_hc
//  o_vs_raw         unregistered vsync (active low) for o_vc
//  o_visible        o_hc/o_vc lie inside the 640x480 active area
// Reset parks the raster at hc=640, vc=524 so the line-0 prefetch happens
// during the blanking that precedes the first visible line.
module vga_timing
  import vga_pkg::*;
#(
  parameter int PIX_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  output logic       o_tick,
  output logic [9:0] o_hc,
  output logic [9:0] o_vc,
  output logic       o_hs_raw,
  output logic       o_vs_raw,
  output logic       o_visible
);

  localparam int DIV_W = clog2_min1(PIX_DIV);

  logic [DIV_W-1:0] r_div;
  logic [9:0]       r_hc;
  logic [9:0]       r_vc;
  logic             w_tick;

  assign w_tick = (r_div == DIV_W'(PIX_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= '0;
      r_hc  <= H_VIS;
      r_vc  <= V_LAST;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_tick) begin
        if (r_hc == H_LAST) begin
          r_hc <= '0;
          r_vc <= (r_vc == V_LAST) ? '0 : r_vc + 1'b1;
        end else begin
          r_hc <= r_hc + 1'b1;
        end
      end
    end
  end

  assign o_tick    = w_tick;
  assign o_hc      = r_hc;
  assign o_vc      = r_vc;
  assign o_hs_raw  = ~((r_hc >= H_SYNC_S) && (r_hc < H_SYNC_E));
  assign o_vs_raw  = ~((r_vc >= V_SYNC_S) && (r_vc < V_SYNC_E));
  assign o_visible = (r_hc < H_VIS) && (r_vc < V_VIS);

endmodule

// File: rtl/vga_fetch.sv
// vga_fetch: VGA scan-out engine for a 1-bpp framebuffer in shared memory.
// Reads framebuffer words through the memory's registered video port and
// expands each bit into an HSCALE x VSCALE block of screen pixels.
// Ports:
//  clk, reset        system clock (shared with memory), sync active-high reset
//  va                registered video read byte address
//  vd                video read data, valid the cycle after va is sampled
//  vga_hs, vga_vs    syncs, active low
//  vga_blank_n       high during the visible area
//  vga_r/g/b         colour channels, 0 outside the visible area
//  fetch_err         sticky underrun flag, cleared only by reset
// Build option: define VGA_FETCH_PALETTE_EN to add fg_rgb/bg_rgb inputs
// (set bits show fg_rgb, clear bits bg_rgb); otherwise white on black.
module vga_fetch
  import vga_pkg::*;
#(
  parameter logic [31:0] FB_BASE = 32'h0000_0200,
  parameter int          FB_W    = 64,
  parameter int          FB_H    = 32,
  parameter int          HSCALE  = 10,
  parameter int          VSCALE  = 15,
  parameter int          PIX_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] va,
  input  logic [31:0] vd,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        fetch_err
`ifdef VGA_FETCH_PALETTE_EN
  ,
  input  logic [23:0] fg_rgb,
  input  logic [23:0] bg_rgb
`endif
);

  localparam int WPL  = FB_W / 32;
  localparam int XS_W = clog2_min1(HSCALE);
  localparam int XC_W = clog2_min1(FB_W);
  localparam int YS_W = clog2_min1(VSCALE);
  localparam int YC_W = clog2_min1(FB_H);
  localparam int WI_W = clog2_min1(WPL);

  logic       w_tick, w_hs_raw, w_vs_raw, w_visible;
  logic [9:0] w_hc, w_vc;

  vga_timing #(.PIX_DIV(PIX_DIV)) u_timing (
    .clk      (clk),
    .reset    (reset),
    .o_tick   (w_tick),
    .o_hc     (w_hc),
    .o_vc     (w_vc),
    .o_hs_raw (w_hs_raw),
    .o_vs_raw (w_vs_raw),
    .o_visible(w_visible)
  );

  logic [XS_W-1:0] r_xsub;
  logic [XC_W-1:0] r_xcell;
  logic [YS_W-1:0] r_ysub;
  logic [YC_W-1:0] r_ycell;
  fetch_state_t    r_state;
  logic [31:0]     r_va, r_q_addr, r_cur_word, r_nxt_word;
  logic            r_q_valid, r_nxt_valid, r_underrun, r_fetch_err;
  logic [YC_W-1:0] r_fetch_row;
  logic [WI_W-1:0] r_fetch_word;
  logic            r_hs, r_vs, r_blank_n;
  rgb_t            r_rgb, w_fg, w_bg;

`ifdef VGA_FETCH_PALETTE_EN
  assign w_fg = rgb_t'(fg_rgb);
  assign w_bg = rgb_t'(bg_rgb);
`else
  assign w_fg = rgb_t'(24'hFF_FFFF);
  assign w_bg = rgb_t'(24'h00_0000);
`endif

  function automatic logic [31:0] word_addr(input logic [YC_W-1:0] row,
                                            input logic [WI_W-1:0] word);
    return FB_BASE + ((32'(row) * 32'(WPL) + 32'(word)) << 2);
  endfunction

  // Next line is visible: either wrapping into line 0 or still inside 0..478.
  logic w_next_vis;
  assign w_next_vis = (w_vc == V_LAST) || (w_vc < (V_VIS - 10'd1));

  // Row that the next line displays; ycell/ysub still describe this line.
  logic [YC_W-1:0] w_next_row;
  always_comb begin
    w_next_row = r_ycell;
    if (w_vc == V_LAST)
      w_next_row = '0;
    else if (r_ysub == YS_W'(VSCALE - 1))
      w_next_row = (r_ycell == YC_W'(FB_H - 1)) ? '0 : r_ycell + 1'b1;
  end

  // Last pixel of a word that is not the final word of the line; the final
  // word is followed by blanking, where the line-start prefetch takes over.
  logic w_word_end;
  assign w_word_end = w_visible && (r_xsub == XS_W'(HSCALE - 1)) &&
                      (r_xcell[4:0] == 5'd31) &&
                      ((32'(r_xcell) >> 5) != 32'(WPL - 1));

  logic        w_swap, w_line_trig, w_swap_trig, w_trig;
  logic [31:0] w_trig_addr;
  assign w_swap      = w_tick && (w_word_end || ((w_hc == H_LAST) && w_next_vis));
  assign w_line_trig = w_tick && (w_hc == H_VIS) && w_next_vis;
  assign w_swap_trig = w_swap && (r_fetch_word != WI_W'(WPL - 1));
  assign w_trig      = w_line_trig || w_swap_trig;
  assign w_trig_addr = w_line_trig ? word_addr(w_next_row, '0)
                                   : word_addr(r_fetch_row, WI_W'(r_fetch_word + 1'b1));

  // Fetch FSM plus word buffers; swap and capture share state so they live here.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_va         <= FB_BASE;
      r_q_valid    <= 1'b0;
      r_q_addr     <= FB_BASE;
      r_cur_word   <= '0;
      r_nxt_word   <= '0;
      r_nxt_valid  <= 1'b0;
      r_underrun   <= 1'b0;
      r_fetch_err  <= 1'b0;
      r_fetch_row  <= '0;
      r_fetch_word <= '0;
    end else begin
      if (w_line_trig) begin
        r_fetch_row  <= w_next_row;
        r_fetch_word <= '0;
      end else if (w_swap_trig) begin
        r_fetch_word <= r_fetch_word + 1'b1;
      end

      if (w_swap) begin
        r_cur_word  <= r_nxt_word;
        r_nxt_valid <= 1'b0;
        // Underrun blanks to bg until the following swap.
        r_underrun  <= ~r_nxt_valid;
        if (!r_nxt_valid)
          r_fetch_err <= 1'b1;
      end

      // One-deep queue for a trigger that cannot be issued this cycle.
      if (w_trig && ((r_state != IDLE) || r_q_valid)) begin
        r_q_valid <= 1'b1;
        r_q_addr  <= w_trig_addr;
      end

      case (r_state)
        IDLE: begin
          if (r_q_valid) begin
            r_va    <= r_q_addr;
            r_state <= ADDR;
            if (!w_trig)
              r_q_valid <= 1'b0;
          end else if (w_trig) begin
            r_va    <= w_trig_addr;
            r_state <= ADDR;
          end
        end
        ADDR: r_state <= WAIT;
        WAIT: r_state <= CAPT;
        CAPT: begin
          r_nxt_word  <= vd;
          r_nxt_valid <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  logic w_bit;
  assign w_bit = ~r_underrun & r_cur_word[r_xcell[4:0]];

  // Cell counters and registered outputs; everything advances on ticks only.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_xsub    <= '0;
      r_xcell   <= '0;
      r_ysub    <= '0;
      r_ycell   <= '0;
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_blank_n <= 1'b0;
      r_rgb     <= '0;
    end else if (w_tick) begin
      if (w_visible) begin
        if (r_xsub == XS_W'(HSCALE - 1)) begin
          r_xsub  <= '0;
          r_xcell <= (r_xcell == XC_W'(FB_W - 1)) ? '0 : r_xcell + 1'b1;
        end else begin
          r_xsub <= r_xsub + 1'b1;
        end
      end else begin
        r_xsub  <= '0;
        r_xcell <= '0;
      end

      if (w_hc == H_LAST) begin
        if (w_vc == V_LAST) begin
          r_ysub  <= '0;
          r_ycell <= '0;
        end else if (w_vc < V_VIS) begin
          if (r_ysub == YS_W'(VSCALE - 1)) begin
            r_ysub  <= '0;
            r_ycell <= (r_ycell == YC_W'(FB_H - 1)) ? '0 : r_ycell + 1'b1;
          end else begin
            r_ysub <= r_ysub + 1'b1;
          end
        end
      end

      r_hs      <= w_hs_raw;
      r_vs      <= w_vs_raw;
      r_blank_n <= w_visible;
      r_rgb     <= w_visible ? (w_bit ? w_fg : w_bg) : '0;
    end
  end

  assign va          = r_va;
  assign vga_hs      = r_hs;
  assign vga_vs      = r_vs;
  assign vga_blank_n = r_blank_n;
  assign vga_r       = r_rgb.r;
  assign vga_g       = r_rgb.g;
  assign vga_b       = r_rgb.b;
  assign fetch_err   = r_fetch_err;

endmodule

// File: tb/tb_vga_fetch.sv
// tb_vga_fetch: directed bench for vga_fetch paired with a registered-read
// memory model. Output position is derived from the tick count since reset
// release: the outputs after tick n show raster position n-1 counted from
// (hc=640, vc=524). Lines 0..16 are captured and checked against a table.
`timescale 1ns/1ps
module tb_vga_fetch;

  localparam logic [31:0] FB_BASE = 32'h0000_0200;
  localparam int NL = 17;
  localparam int NV = 24;
`ifdef VGA_FETCH_PALETTE_EN
  localparam logic [23:0] FG = 24'h00FF00;
  localparam logic [23:0] BG = 24'h000080;
`else
  localparam logic [23:0] FG = 24'hFFFFFF;
  localparam logic [23:0] BG = 24'h000000;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] va;
  logic [31:0] vd;
  logic        vga_hs, vga_vs, vga_blank_n, fetch_err;
  logic [7:0]  vga_r, vga_g, vga_b;
`ifdef VGA_FETCH_PALETTE_EN
  logic [23:0] fg_rgb = FG;
  logic [23:0] bg_rgb = BG;
`endif

  always #5 clk = ~clk;

  vga_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .va         (va),
    .vd         (vd),
    .vga_hs     (vga_hs),
    .vga_vs     (vga_vs),
    .vga_blank_n(vga_blank_n),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .fetch_err  (fetch_err)
`ifdef VGA_FETCH_PALETTE_EN
    ,
    .fg_rgb     (fg_rgb),
    .bg_rgb     (bg_rgb)
`endif
  );

  // Memory model: one-clock registered read of the video port.
  logic [31:0] mem [0:63];
  logic [31:0] mem_off;
  assign mem_off = va - FB_BASE;
  always @(posedge clk)
    vd <= (va >= FB_BASE && va < FB_BASE + 32'd256) ? mem[mem_off[7:2]] : 32'hDEAD_BEEF;

  typedef struct packed {
    int          x;
    int          y;
    logic [23:0] rgb;
    logic        blank_n;
    logic        hs;
  } vec_t;
  vec_t vecs [NV];

  int checks = 0;
  int errors = 0;
  int cyc, p, hc_m, vc_m, first_vis, vs_low, bad_va;
  bit log_en;
  logic [31:0] va_prev;
  logic [31:0] va_log [$];
  logic [23:0] cap_rgb   [0:NL-1][0:799];
  logic        cap_blank [0:NL-1][0:799];
  logic        cap_hs    [0:NL-1][0:799];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_run();
    for (int y = 0; y < NL; y++)
      for (int x = 0; x < 800; x++) begin
        cap_rgb[y][x] = 'x;
        cap_blank[y][x] = 1'bx;
        cap_hs[y][x] = 1'bx;
      end
    cyc = 0; p = -1; first_vis = 0; vs_low = 0; bad_va = 0;
    va_prev = va;
    va_log.delete();
    reset = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (cyc % 2 == 0) begin
      p = cyc / 2 - 1;
      if (p < 160) begin hc_m = 640 + p; vc_m = 524; end
      else begin hc_m = (p - 160) % 800; vc_m = (p - 160) / 800; end
    end
    @(negedge clk);
    if (cyc % 2 == 0 && vc_m < NL) begin
      cap_rgb[vc_m][hc_m]   = {vga_r, vga_g, vga_b};
      cap_blank[vc_m][hc_m] = vga_blank_n;
      cap_hs[vc_m][hc_m]    = vga_hs;
    end
    if (vga_blank_n === 1'b1 && first_vis == 0) first_vis = cyc;
    if (vga_vs !== 1'b1) vs_low++;
    if (va < FB_BASE || va > FB_BASE + 32'd252) bad_va++;
    if (va !== va_prev) begin
      if (log_en && p >= 0 && ((vc_m == 14 && hc_m >= 640) || (vc_m == 15 && hc_m < 640)))
        va_log.push_back(va);
      va_prev = va;
    end
  endtask

  task automatic run_until(input int target);
    int guard;
    guard = 0;
    while (p < target && guard < 40000) begin
      step();
      guard++;
    end
    if (p < target) begin
      errors++;
      $display("FAIL run_timeout: reached position %0d of %0d", p, target);
    end
  endtask

  task automatic run_checks(input string tag);
    int nb, nh, nf;
    for (int i = 0; i < NV; i++) begin
      check($sformatf("%s vec%0d rgb (%0d,%0d)", tag, i, vecs[i].x, vecs[i].y),
            32'(cap_rgb[vecs[i].y][vecs[i].x]), 32'(vecs[i].rgb));
      check($sformatf("%s vec%0d blank_n", tag, i),
            32'(cap_blank[vecs[i].y][vecs[i].x]), 32'(vecs[i].blank_n));
      check($sformatf("%s vec%0d hs", tag, i),
            32'(cap_hs[vecs[i].y][vecs[i].x]), 32'(vecs[i].hs));
    end
    // Every row has exactly two lit 10-pixel cells in this image.
    for (int y = 0; y < NL; y++) begin
      nb = 0; nh = 0; nf = 0;
      for (int x = 0; x < 800; x++) begin
        if (cap_blank[y][x] === 1'b1) nb++;
        if (cap_hs[y][x] === 1'b0) nh++;
        if (cap_blank[y][x] === 1'b1 && cap_rgb[y][x] === FG) nf++;
      end
      check($sformatf("%s line%0d blank_n count", tag, y), 32'(nb), 32'd640);
      check($sformatf("%s line%0d hs low count", tag, y), 32'(nh), 32'd96);
      check($sformatf("%s line%0d fg count", tag, y), 32'(nf), 32'd20);
    end
    check($sformatf("%s vs low samples", tag), 32'(vs_low), 32'd0);
    check($sformatf("%s va out of range samples", tag), 32'(bad_va), 32'd0);
    check($sformatf("%s fetch_err", tag), 32'(fetch_err), 32'd0);
    // Counters reach hc=0,vc=0 after 160 ticks (edge 320); registered output one tick later.
    check($sformatf("%s first visible clk", tag), 32'(first_vis), 32'd322);
  endtask

  task automatic check_reset_state(input string tag);
    check($sformatf("%s reset hs", tag), 32'(vga_hs), 32'd1);
    check($sformatf("%s reset vs", tag), 32'(vga_vs), 32'd1);
    check($sformatf("%s reset blank_n", tag), 32'(vga_blank_n), 32'd0);
    check($sformatf("%s reset rgb", tag), 32'({vga_r, vga_g, vga_b}), 32'd0);
    check($sformatf("%s reset va", tag), va, FB_BASE);
    check($sformatf("%s reset fetch_err", tag), 32'(fetch_err), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[0] = 32'h0000_0001;   // row 0 cell 0   -> x 0-9
    mem[1] = 32'h8000_0000;   // row 0 cell 63  -> x 630-639
    mem[2] = 32'h0000_0100;   // row 1 cell 8   -> x 80-89
    mem[3] = 32'h0000_0010;   // row 1 cell 36  -> x 360-369

    vecs[0]  = '{0,   0,  FG,     1'b1, 1'b1};
    vecs[1]  = '{9,   0,  FG,     1'b1, 1'b1};
    vecs[2]  = '{10,  0,  BG,     1'b1, 1'b1};
    vecs[3]  = '{319, 0,  BG,     1'b1, 1'b1};
    vecs[4]  = '{320, 0,  BG,     1'b1, 1'b1};
    vecs[5]  = '{629, 0,  BG,     1'b1, 1'b1};
    vecs[6]  = '{630, 0,  FG,     1'b1, 1'b1};
    vecs[7]  = '{639, 14, FG,     1'b1, 1'b1};
    vecs[8]  = '{0,   14, FG,     1'b1, 1'b1};
    vecs[9]  = '{0,   15, BG,     1'b1, 1'b1};
    vecs[10] = '{639, 15, BG,     1'b1, 1'b1};
    vecs[11] = '{80,  15, FG,     1'b1, 1'b1};
    vecs[12] = '{79,  15, BG,     1'b1, 1'b1};
    vecs[13] = '{89,  16, FG,     1'b1, 1'b1};
    vecs[14] = '{90,  16, BG,     1'b1, 1'b1};
    vecs[15] = '{360, 16, FG,     1'b1, 1'b1};
    vecs[16] = '{369, 16, FG,     1'b1, 1'b1};
    vecs[17] = '{370, 16, BG,     1'b1, 1'b1};
    vecs[18] = '{640, 0,  24'h0,  1'b0, 1'b1};
    vecs[19] = '{655, 3,  24'h0,  1'b0, 1'b1};
    vecs[20] = '{656, 3,  24'h0,  1'b0, 1'b0};
    vecs[21] = '{751, 3,  24'h0,  1'b0, 1'b0};
    vecs[22] = '{752, 3,  24'h0,  1'b0, 1'b1};
    vecs[23] = '{799, 16, 24'h0,  1'b0, 1'b1};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("por");

    // Run A: power-on start, through line 16 and into the middle of line 17.
    log_en = 1'b1;
    start_run();
    run_until(160 + 17 * 800 + 300);
    run_checks("A");
    check("A va log length", 32'(va_log.size()), 32'd2);
    check("A va first fetch row1", (va_log.size() > 0) ? va_log[0] : 32'h0, 32'h0000_0208);
    check("A va second fetch row1", (va_log.size() > 1) ? va_log[1] : 32'h0, 32'h0000_020C);

    // Mid-line reset pulse: state must be back at reset values after one clk.
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_state("midline");

    // Run B: after release the frame restarts cleanly with the same image.
    log_en = 1'b0;
    start_run();
    run_until(160 + 17 * 800 - 1);
    run_checks("B");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
